ssd_mux_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode seven-segment display.

---
 rtl/ssd_mux_if.sv | 30 +++
 rtl/ssd_mux_driver.sv | 138 +++++++++++++
 tb/tb_ssd_mux_driver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ssd_mux_if.sv
// Bus between the display-register side and the seven-segment scan driver.
// Carries the snapshot inputs, the pin-level segment/anode outputs and debug taps.
interface ssd_mux_if #(
  parameter int N_DIGITS = 4
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  // in_load is a one-cycle capture strobe with no ready: the driver accepts it on
  // every edge in every state, so the master never has to wait or hold it.
  logic                    in_en;
  logic                    in_load;
  logic [4*N_DIGITS-1:0]   in_value;
  logic [N_DIGITS-1:0]     in_dp;
  logic [N_DIGITS-1:0]     in_blank;
  logic [6:0]              out_SSD;
  logic                    out_dp;
  logic [N_DIGITS-1:0]     out_AN;
  logic [IW-1:0]           out_digit_idx;
  logic [1:0]              out_state;

  modport master (
    output in_en, in_load, in_value, in_dp, in_blank,
    input  out_SSD, out_dp, out_AN, out_digit_idx, out_state
  );

  modport slave (
    input  in_en, in_load, in_value, in_dp, in_blank,
    output out_SSD, out_dp, out_AN, out_digit_idx, out_state
  );
endinterface

// File: rtl/ssd_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadowed value, per-slot dead
// time, hex decode, decimal points, per-digit blanking and leading-zero suppression.
module ssd_mux_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 16,
  parameter int LZ_BLANK    = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  ssd_mux_if.slave  bus
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, DEAD = 2'd1, ON = 2'd2} state_t;

  state_t                state, state_nx;
  logic [PW-1:0]         presc, presc_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [4*N_DIGITS-1:0] sh_value;
  logic [N_DIGITS-1:0]   sh_dp, sh_blank;
  logic [6:0]            ssd_q, ssd_nx;
  logic                  dp_q, dp_nx;
  logic [N_DIGITS-1:0]   an_q, an_nx;
  logic [IW-1:0]         idx_q;
  logic                  upper_zero, digit_off;
  logic [3:0]            nibble;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0000100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i >= int'(idx) && sh_value[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    digit_off = sh_blank[idx] || ((LZ_BLANK != 0) && (idx != '0) && upper_zero);
    nibble    = sh_value[4*int'(idx) +: 4];
  end

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        presc_nx = '0;
        idx_nx   = '0;
        if (bus.in_en) state_nx = DEAD;
      end
      DEAD: begin
        presc_nx = presc + 1'b1;
        if (presc == PW'(DEAD_CYC - 1)) state_nx = ON;
      end
      ON: begin
        if (presc == PW'(REFRESH_DIV - 1)) begin
          presc_nx = '0;
          idx_nx   = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
          state_nx = DEAD;
        end else begin
          presc_nx = presc + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Disable wins over every slot transition and restarts the scan at digit 0.
    if (!bus.in_en) begin
      state_nx = IDLE;
      presc_nx = '0;
      idx_nx   = '0;
    end
  end

  always_comb begin
    an_nx  = '1;
    ssd_nx = 7'h7F;
    dp_nx  = 1'b1;
    if (state == ON && !digit_off) begin
      an_nx[idx] = 1'b0;
      ssd_nx     = seg_decode(nibble);
      dp_nx      = ~sh_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      idx      <= '0;
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      ssd_q    <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= '1;
      idx_q    <= '0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      idx   <= idx_nx;
      if (bus.in_load) begin
        sh_value <= bus.in_value;
        sh_dp    <= bus.in_dp;
        sh_blank <= bus.in_blank;
      end
      ssd_q <= ssd_nx;
      dp_q  <= dp_nx;
      an_q  <= an_nx;
      idx_q <= idx;
    end
  end

  assign bus.out_SSD       = ssd_q;
  assign bus.out_dp        = dp_q;
  assign bus.out_AN        = an_q;
  assign bus.out_digit_idx = idx_q;
  assign bus.out_state     = state;
endmodule

// File: tb/tb_ssd_mux_driver.sv
// Randomized and directed bench for ssd_mux_driver, one instance with leading-zero
// suppression and one without, both checked against a slot/phase timing model.
module tb_ssd_mux_driver;
  localparam int N  = 4;
  localparam int R  = 8;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en = 1'b0, load = 1'b0;
  logic [15:0] val = '0;
  logic [3:0]  dp = '0, blank = '0;

  ssd_mux_if #(.N_DIGITS(N)) bus_lz ();
  ssd_mux_if #(.N_DIGITS(N)) bus_nl ();

  assign bus_lz.in_en = en;   assign bus_nl.in_en = en;
  assign bus_lz.in_load = load; assign bus_nl.in_load = load;
  assign bus_lz.in_value = val; assign bus_nl.in_value = val;
  assign bus_lz.in_dp = dp;   assign bus_nl.in_dp = dp;
  assign bus_lz.in_blank = blank; assign bus_nl.in_blank = blank;

  ssd_mux_driver #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYC(DC), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .bus(bus_lz));
  ssd_mux_driver #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYC(DC), .LZ_BLANK(0)) dut_nl (
    .clk(clk), .rst_n(rst_n), .bus(bus_nl));

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model: scan position is just the cycle count since enable.
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0, m_blank = '0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_out(input bit lz, output logic [6:0] ssd, output logic dpo,
                         output logic [3:0] an, output logic [1:0] ix);
    int p, d, nib;
    bit off;
    ssd = 7'h7F; dpo = 1'b1; an = 4'hF; ix = 2'd0;
    if (m_active) begin
      p   = m_t % R;
      d   = (m_t / R) % N;
      ix  = 2'(d);
      nib = int'((m_val >> (4*d)) & 16'hF);
      off = m_blank[d] || (lz && d > 0 && (m_val >> (4*d)) == 16'd0);
      if (p >= DC && !off) begin
        an  = ~(4'b0001 << d);
        ssd = seg_tab[nib];
        dpo = ~m_dp[d];
      end
    end
  endtask

  task automatic model_step();
    if (!en) begin
      m_active = 1'b0; m_t = 0;
    end else if (!m_active) begin
      m_active = 1'b1; m_t = 0;
    end else begin
      m_t++;
    end
    if (load) begin
      m_val = val; m_dp = dp; m_blank = blank;
    end
  endtask

  task automatic tick();
    logic [6:0] s1, s0;
    logic d1, d0;
    logic [3:0] a1, a0;
    logic [1:0] i1, i0;
    @(posedge clk);
    exp_out(1'b1, s1, d1, a1, i1);
    exp_out(1'b0, s0, d0, a0, i0);
    model_step();
    exp_q.push_back({s1, d1, a1, i1});
    exp_q.push_back({s0, d0, a0, i0});
    #1;
    begin
      logic [13:0] e;
      e = 14'(exp_q.pop_front());
      check_eq("lz_ssd", 32'(bus_lz.out_SSD), 32'(e[13:7]));
      check_eq("lz_dp",  32'(bus_lz.out_dp),  32'(e[6]));
      check_eq("lz_an",  32'(bus_lz.out_AN),  32'(e[5:2]));
      check_eq("lz_idx", 32'(bus_lz.out_digit_idx), 32'(e[1:0]));
      e = 14'(exp_q.pop_front());
      check_eq("nl_ssd", 32'(bus_nl.out_SSD), 32'(e[13:7]));
      check_eq("nl_dp",  32'(bus_nl.out_dp),  32'(e[6]));
      check_eq("nl_an",  32'(bus_nl.out_AN),  32'(e[5:2]));
      check_eq("nl_idx", 32'(bus_nl.out_digit_idx), 32'(e[1:0]));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    val = v; dp = d; blank = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_lz_an"}, 32'(bus_lz.out_AN), 32'hF);
    check_eq({tag, "_lz_ssd"}, 32'(bus_lz.out_SSD), 32'h7F);
    check_eq({tag, "_lz_dp"}, 32'(bus_lz.out_dp), 32'h1);
    check_eq({tag, "_lz_idx"}, 32'(bus_lz.out_digit_idx), 32'h0);
    check_eq({tag, "_nl_an"}, 32'(bus_nl.out_AN), 32'hF);
    check_eq({tag, "_nl_ssd"}, 32'(bus_nl.out_SSD), 32'h7F);
  endtask

  initial begin
    // Clock/reset
    #12;
    check_dark("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Scan of 12AF with dp on digit 2, over more than one full frame.
    do_load(16'h12AF, 4'b0100, 4'b0000);
    en = 1'b1;
    run(4*R + 10);

    // Leading-zero suppression versus plain display.
    do_load(16'h0007, 4'b0000, 4'b0000);
    run(4*R + 2);
    do_load(16'h0000, 4'b0000, 4'b0000);
    run(4*R + 2);

    // Blank mask on digits 1 and 3.
    do_load(16'h8888, 4'b0000, 4'b1010);
    run(4*R + 2);

    // Input changes without a load must not reach the display.
    do_load(16'h4321, 4'b0001, 4'b0000);
    val = 16'hFFFF; dp = 4'b1111; blank = 4'b1111;
    run(2*R + 3);
    // Load while digit 2 is lit.
    for (int k = 0; k < 4*R && !(m_active && (m_t / R) % N == 2 && m_t % R == 4); k++) tick();
    check_eq("reach_digit2", 32'((m_t / R) % N), 32'd2);
    do_load(16'h0900, 4'b0000, 4'b0000);
    run(R);

    // Disable mid-slot, then re-enable.
    run(3);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(2*R + 4);

    // Random traffic.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        load  = 1'b1;
        val   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        dp    = 4'($urandom);
        blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      end
      if ($urandom_range(0, 79) == 0) en = ~en;
      tick();
      load = 1'b0;
    end

    // Asynchronous reset while a digit is lit.
    en = 1'b1;
    do_load(16'h1234, 4'b1111, 4'b0000);
    for (int k = 0; k < 4*R && bus_lz.out_AN == 4'hF; k++) tick();
    check_eq("lit_before_reset", 32'(bus_lz.out_AN != 4'hF), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_dark("async_rst");
    m_active = 1'b0; m_t = 0; m_val = '0; m_dp = '0; m_blank = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run(R + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
